// File: rtl/decade_2421_checker_if.sv
// rtl/decade_2421_checker_if.sv - code stream and monitor outputs of the 2421 checker
//
// Purpose: bundles the 2421 sample stream and the decoded/monitor results.
// Ports:
//   in_valid, code_in          : sample strobe and 4-bit 2421 code (source -> checker)
//   digit, digit_valid         : last valid BCD digit and its update pulse
//   code_err, seq_err, wrap    : one-cycle event pulses
//   locked                     : checker holds a trusted reference
//   wrap_count, err_count      : saturating event counters
// Modports: master = code source / consumer, slave = checker.
interface decade_2421_checker_if #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
);
    logic              in_valid;
    logic [3:0]        code_in;
    logic [3:0]        digit;
    logic              digit_valid;
    logic              code_err;
    logic              seq_err;
    logic              wrap;
    logic              locked;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output in_valid, code_in,
        input  digit, digit_valid, code_err, seq_err, wrap, locked, wrap_count, err_count
    );

    modport slave (
        input  in_valid, code_in,
        output digit, digit_valid, code_err, seq_err, wrap, locked, wrap_count, err_count
    );
endinterface

// File: rtl/decade_2421_checker.sv
// rtl/decade_2421_checker.sv - 2421 (Aiken) decade decoder and sequence monitor
//
// Purpose: decodes a sampled 2421 code stream to BCD, rejects the six invalid
// words, checks that consecutive samples hold or advance by one mod 10, and
// counts decade wraps and errors (both counters saturate).
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : decade_2421_checker_if.slave (stream in, monitor outputs out)
module decade_2421_checker #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    decade_2421_checker_if.slave  bus
);
    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t            state;
    logic [3:0]        digit;
    logic              digit_valid;
    logic              code_err;
    logic              seq_err;
    logic              wrap;
    logic              locked;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;

    logic              code_ok;
    logic [3:0]        value;
    logic [3:0]        next_digit;

    // 0000-0100 are digits 0-4, 1011-1111 are digits 5-9 (code - 6).
    // digit is only ever written with an accepted value, so it also serves
    // as the reference of the last accepted digit.
    always_comb begin
        code_ok    = (bus.code_in <= 4'd4) || (bus.code_in >= 4'd11);
        value      = (bus.code_in <= 4'd4) ? bus.code_in : bus.code_in - 4'd6;
        next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            locked      <= 1'b0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            wrap        <= 1'b0;
            wrap_count  <= '0;
            err_count   <= '0;
        end else begin
            digit_valid <= 1'b0;
            code_err    <= 1'b0;
            seq_err     <= 1'b0;
            wrap        <= 1'b0;
            if (bus.in_valid) begin
                if (!code_ok) begin
                    // An invalid word drops the reference; digit keeps its last value.
                    code_err <= 1'b1;
                    state    <= SYNC;
                    locked   <= 1'b0;
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                end else if (state == SYNC) begin
                    digit       <= value;
                    digit_valid <= 1'b1;
                    state       <= TRACK;
                    locked      <= 1'b1;
                end else begin
                    digit_valid <= 1'b1;
                    if (value == next_digit) begin
                        digit <= value;
                        if (digit == 4'd9) begin
                            wrap <= 1'b1;
                            if (wrap_count != '1) begin
                                wrap_count <= wrap_count + 1'b1;
                            end
                        end
                    end else if (value != digit) begin
                        // Illegal jump: flag it and relock on the new value.
                        seq_err <= 1'b1;
                        digit   <= value;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.digit       = digit;
    assign bus.digit_valid = digit_valid;
    assign bus.code_err    = code_err;
    assign bus.seq_err     = seq_err;
    assign bus.wrap        = wrap;
    assign bus.locked      = locked;
    assign bus.wrap_count  = wrap_count;
    assign bus.err_count   = err_count;
endmodule

// File: tb/tb_decade_2421_checker.sv
// tb/tb_decade_2421_checker.sv - self-checking bench for decade_2421_checker
module tb_decade_2421_checker;
    localparam int WRAP_W = 2;
    localparam int ERR_W  = 4;
    localparam int WMAX   = (1 << WRAP_W) - 1;
    localparam int EMAX   = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decade_2421_checker_if #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

    decade_2421_checker #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit rst;
        bit v;
        int code;
        int digit;
        bit dv;
        bit ce;
        bit se;
        bit wr;
        bit lk;
        int wc;
        int ec;
    } vec_t;

    vec_t vecs[$];
    int   enc[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
    int   errors = 0;
    int   checks = 0;

    // Reference model state.
    bit m_lock;
    int m_dig, m_wc, m_ec;
    bit m_dv, m_ce, m_se, m_wr;

    task automatic add(input bit r, input bit v, input int code, input int d, input bit dv,
                       input bit ce, input bit se, input bit wr, input bit lk,
                       input int wc, input int ec);
        vec_t t;
        t = '{r, v, code, d, dv, ce, se, wr, lk, wc, ec};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge sample, return at the next falling edge.
    task automatic apply(input bit r, input bit v, input int code);
        reset        = r;
        bus.in_valid = v;
        bus.code_in  = 4'(code);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int d, input bit dv, input bit ce,
                             input bit se, input bit wr, input bit lk, input int wc, input int ec);
        chk({tag, ".digit"},       int'(bus.digit),       d);
        chk({tag, ".digit_valid"}, int'(bus.digit_valid), int'(dv));
        chk({tag, ".code_err"},    int'(bus.code_err),    int'(ce));
        chk({tag, ".seq_err"},     int'(bus.seq_err),     int'(se));
        chk({tag, ".wrap"},        int'(bus.wrap),        int'(wr));
        chk({tag, ".locked"},      int'(bus.locked),      int'(lk));
        chk({tag, ".wrap_count"},  int'(bus.wrap_count),  wc);
        chk({tag, ".err_count"},   int'(bus.err_count),   ec);
    endtask

    function automatic int decode(input int code);
        for (int d = 0; d < 10; d++) begin
            if (enc[d] == code) return d;
        end
        return -1;
    endfunction

    function automatic int sat_inc(input int c, input int max);
        return (c < max) ? c + 1 : max;
    endfunction

    task automatic model_step(input bit r, input bit v, input int code);
        int d;
        m_dv = 0; m_ce = 0; m_se = 0; m_wr = 0;
        if (r) begin
            m_lock = 0; m_dig = 0; m_wc = 0; m_ec = 0;
        end else if (v) begin
            d = decode(code);
            if (d < 0) begin
                m_ce = 1; m_ec = sat_inc(m_ec, EMAX); m_lock = 0;
            end else if (!m_lock) begin
                m_dig = d; m_dv = 1; m_lock = 1;
            end else begin
                m_dv = 1;
                if (d == (m_dig + 1) % 10) begin
                    if (m_dig == 9) begin
                        m_wr = 1; m_wc = sat_inc(m_wc, WMAX);
                    end
                end else if (d != m_dig) begin
                    m_se = 1; m_ec = sat_inc(m_ec, EMAX);
                end
                m_dig = d;
            end
        end
    endtask

    initial begin
        int k;
        int dg;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.code_in  = 4'd0;

        // Reset, then count 0..9,0
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j <= 10; j++) begin
            dg = j % 10;
            add(0, 1, enc[dg], dg, 1, 0, 0, (j == 10), 1, (j == 10) ? 1 : 0, 0);
        end
        // Hold with idle gaps
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0011, 3, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 4'b0000, 3, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 4'b0011, 3, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 4'b1111, 3, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 4'b0011, 3, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 4'b0101, 3, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 4'b0100, 4, 1, 0, 0, 0, 1, 0, 0);
        // Invalid sweep from digit 4, then relock on 5
        add(0, 1, 4'b0101, 4, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 4'b1010, 4, 0, 1, 0, 0, 0, 0, 2);
        add(0, 1, 4'b1011, 5, 1, 0, 0, 0, 1, 0, 2);
        // 5 -> 2 and 2 -> 6 are skips, 6 -> 7 is clean
        add(0, 1, 4'b0010, 2, 1, 0, 1, 0, 1, 0, 3);
        add(0, 1, 4'b1100, 6, 1, 0, 1, 0, 1, 0, 4);
        add(0, 1, 4'b1101, 7, 1, 0, 0, 0, 1, 0, 4);
        // Reset coincident with a valid sample, then relock on 9
        add(1, 1, 4'b1110, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4'b1111, 9, 1, 0, 0, 0, 1, 0, 0);
        // Wrap counter saturation over five decades
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int kk = 1; kk <= 5; kk++) begin
            for (int j = 1; j <= 10; j++) begin
                dg = j % 10;
                k  = (dg == 0) ? kk : kk - 1;
                add(0, 1, enc[dg], dg, 1, 0, 0, (dg == 0), 1, (k > WMAX) ? WMAX : k, 0);
            end
        end
        // Error counter saturation, relock in SYNC, seq_err at saturation
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            add(0, 1, 4'b0110, 0, 0, 1, 0, 0, 0, 0, (i > EMAX) ? EMAX : i);
        end
        add(0, 1, 4'b1011, 5, 1, 0, 0, 0, 1, 0, EMAX);
        add(0, 1, 4'b0000, 0, 1, 0, 1, 0, 1, 0, EMAX);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].v, vecs[i].code);
            check_all($sformatf("vec%0d", i), vecs[i].digit, vecs[i].dv, vecs[i].ce,
                      vecs[i].se, vecs[i].wr, vecs[i].lk, vecs[i].wc, vecs[i].ec);
        end

        // Randomized run against the reference model
        model_step(1, 0, 0);
        apply(1, 0, 0);
        check_all("rnd_reset", m_dig, m_dv, m_ce, m_se, m_wr, m_lock, m_wc, m_ec);
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            int code;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) begin
                code = enc[(m_dig + int'($urandom_range(0, 1))) % 10];
            end else begin
                code = int'($urandom_range(0, 15));
            end
            model_step(r, v, code);
            apply(r, v, code);
            check_all("rnd", m_dig, m_dv, m_ce, m_se, m_wr, m_lock, m_wc, m_ec);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decade_2421_checker.md
# decade_2421_checker

Receive-side companion for a 2421 (Aiken) decade counter. The block samples a 4-bit 2421 code stream, decodes each code to a BCD digit, and rejects the six invalid code words. It also checks that consecutive samples follow the counter's legal sequence (hold or +1 mod 10) and counts decade wrap-arounds and errors. It sits downstream of the counter, or of any 2421 source, as a decoder and on-line integrity monitor.

## Interface
- WRAP_W, 8, width of wrap counter (saturating)
- ERR_W, 8, width of error counter (saturating)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  code_in is sampled on this cycle
- code_in  in  4  2421 code word (bit3 weight 2, bit2 weight 4, bit1 weight 2, bit0 weight 1)
- digit  out  4  last valid decoded BCD digit 0-9
- digit_valid  out  1  one-cycle pulse: digit updated this cycle
- code_err  out  1  one-cycle pulse: invalid code sampled
- seq_err  out  1  one-cycle pulse: illegal transition sampled
- wrap  out  1  one-cycle pulse: 9 -> 0 transition accepted
- locked  out  1  high while state is TRACK
- wrap_count  out  WRAP_W  accepted wraps, saturates at all-ones
- err_count  out  ERR_W  code_err + seq_err events, saturates at all-ones

## Operation
- Decode is combinational on code_in and registered into digit.
- Valid codes: 0000-0100 map to 0-4; 1011, 1100, 1101, 1110, 1111 map to 5-9 (value = code - 6).
- Invalid codes: 0101-1010. Such a code never updates digit.
- Registers: state, prev (last accepted digit), digit, wrap_count, err_count, and the pulse outputs.
- FSM states:
  - SYNC (reset state): no reference held.
  - TRACK: prev is a trusted reference.
- SYNC, in_valid, valid code: digit = prev = value; digit_valid = 1; go to TRACK. No seq check, no wrap.
- SYNC, in_valid, invalid code: code_err = 1; err_count +1; stay in SYNC.
- TRACK, in_valid, valid code, value == prev (hold, counter enable low): digit_valid = 1; stay in TRACK.
- TRACK, in_valid, valid code, value == (prev+1) mod 10: digit = prev = value; digit_valid = 1. If prev == 9, also wrap = 1 and wrap_count +1.
- TRACK, in_valid, valid code, any other value:
  - seq_err = 1; err_count +1; digit = prev = value; digit_valid = 1.
  - Stay in TRACK, relocked on the new value.
  - No wrap, even if the jump crosses 0.
- TRACK, in_valid, invalid code: code_err = 1; err_count +1; go to SYNC; digit and prev unchanged.
- in_valid low: all pulses 0; state, digit, prev and counters hold.
- Counter saturation: an increment at all-ones leaves the counter at all-ones. Pulse outputs still fire.
- At most one of code_err and seq_err is asserted per cycle. A code_err or seq_err event increments err_count by exactly 1.

## Timing
- Single-cycle latency: a code sampled at rising edge N has its outputs visible after edge N, i.e. during cycle N+1.
- Pulses last exactly one cycle. Back-to-back in_valid samples produce back-to-back pulses with no bubble.
- No backpressure: the block accepts in_valid on every cycle.
- Reset values: state SYNC, locked 0, digit 0000, prev 0, digit_valid 0, code_err 0, seq_err 0, wrap 0, wrap_count 0, err_count 0.
- reset dominates in_valid in the same cycle. Reset mid-stream discards the reference, and the next valid sample re-enters via SYNC without seq_err.
- locked is registered: it goes high the cycle after the first accepted valid code in SYNC, and low the cycle after an invalid code in TRACK.

## Test plan
- Reset, then stream 2421 codes for 0-9 then 0 with in_valid every cycle (0000, 0001, 0010, 0011, 0100, 1011, 1100, 1101, 1110, 1111, 0000):
  - digit follows 0-9, 0; digit_valid every cycle; locked from cycle 2.
  - wrap pulses once on the final 0; wrap_count = 1; err_count = 0.
- Hold and gaps: codes 0011, 0011, 0011, 0100 with in_valid low between samples:
  - no seq_err; digit ends at 4; all pulses 0 on idle cycles.
- Invalid sweep: in TRACK at digit 4, send 0101 then 1010:
  - first: code_err pulse, digit stays 4, locked drops.
  - second: code_err again with state in SYNC; err_count = 2.
  - then 1011 relocks with digit 5 and no seq_err.
- Sequence skip: 0010 followed by 1100 (2 -> 6):
  - seq_err pulse; digit = 6; locked stays 1; err_count +1.
  - next 1101 is accepted cleanly.
- Saturation with WRAP_W = 2: run 5 full decades; wrap_count = 3 after the 3rd wrap and stays 3; the wrap pulse still fires on the 4th and 5th.
- Reset mid-stream at digit 7, asserted in the same cycle as in_valid:
  - all outputs return to their reset values.
  - the next code 1111 relocks with no seq_err and no wrap.
